// File: rtl/dyn_compressor.sv
// dyn_compressor: streaming dynamic-range compressor for signed samples.
// A peak envelope follower tracks |x|. The attack coefficient is
// 2^-ATTACK_SHIFT and the release coefficient is 2^-RELEASE_SHIFT. While the
// envelope exceeds the threshold T, the sample magnitude is reduced by
// over - (over >> R), where over = env - T.
// Ports:
//   i_clk, i_reset     clock; synchronous active-high reset
//   i_valid, i_data    input sample strobe and signed W-bit sample
//   i_threshold        unsigned W-1 bit threshold T
//   i_ratio_shift      ratio exponent R (0 = no reduction)
//   i_bypass           pass the sample unmodified; the envelope still tracks
//   o_valid, o_data    output strobe (i_valid delayed by 2) and signed sample
//   o_env              envelope that was applied to the emitted sample
//   o_active           envelope was above T for the emitted sample
module dyn_compressor #(
   parameter int W             = 8,
   parameter int ATTACK_SHIFT  = 2,
   parameter int RELEASE_SHIFT = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic signed [W-1:0] i_data,
   input  logic        [W-2:0] i_threshold,
   input  logic        [2:0]   i_ratio_shift,
   input  logic                i_bypass,
   output logic                o_valid,
   output logic signed [W-1:0] o_data,
   output logic        [W-2:0] o_env,
   output logic                o_active
);

   localparam logic signed [W-1:0] SMPL_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic        [W-2:0] MAG_MAX  = {(W-1){1'b1}};

   // |x| clipped to W-1 bits; the most negative code has no positive twin.
   function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] x);
      logic signed [W-1:0] neg;
      logic        [W-2:0] res;
      neg = -x;
      if (x == SMPL_MIN)
         res = MAG_MAX;
      else if (x < 0)
         res = neg[W-2:0];
      else
         res = x[W-2:0];
      return res;
   endfunction

   // One envelope step from the old envelope; truncating shifts never overshoot mag.
   function automatic logic [W-2:0] env_step(input logic [W-2:0] env_q,
                                             input logic [W-2:0] mag);
      logic [W-2:0] res;
      if (mag > env_q)
         res = env_q + ((mag - env_q) >> ATTACK_SHIFT);
      else if (mag < env_q)
         res = env_q - ((env_q - mag) >> RELEASE_SHIFT);
      else
         res = env_q;
      return res;
   endfunction

   // Magnitude after gain reduction, floored at zero.
   function automatic logic [W-2:0] sub_sat(input logic [W-2:0] a,
                                            input logic [W-2:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   // Reapply the sign; omag <= 2^(W-1)-1 so the negation cannot wrap.
   function automatic logic signed [W-1:0] apply_sign(input logic          neg,
                                                      input logic [W-2:0] omag);
      logic signed [W-1:0] pos;
      pos = {1'b0, omag};
      return neg ? -pos : pos;
   endfunction

   logic        [W-2:0] env;
   logic                vld_p0;
   logic signed [W-1:0] x_p0;
   logic        [W-2:0] mag_p0;
   logic        [W-2:0] thr_p0;
   logic        [2:0]   ratio_p0;
   logic                byp_p0;

   logic        [W-2:0] mag_in;
   logic        [W-2:0] env_nxt;
   logic        [W-2:0] over_p0;
   logic        [W-2:0] red_p0;
   logic        [W-2:0] omag_p0;
   logic signed [W-1:0] out_p0;

   always_comb begin
      mag_in  = abs_sat(i_data);
      env_nxt = env_step(env, mag_in);
      // env already holds this sample's updated envelope here.
      over_p0 = sub_sat(env, thr_p0);
      red_p0  = over_p0 - (over_p0 >> ratio_p0);
      omag_p0 = sub_sat(mag_p0, red_p0);
      out_p0  = byp_p0 ? x_p0 : apply_sign(x_p0[W-1], omag_p0);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         env      <= '0;
         vld_p0   <= 1'b0;
         x_p0     <= '0;
         mag_p0   <= '0;
         thr_p0   <= '0;
         ratio_p0 <= '0;
         byp_p0   <= 1'b0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_env    <= '0;
         o_active <= 1'b0;
      end else begin
         // Stage 1: accept sample, update envelope, capture per-sample controls.
         vld_p0 <= i_valid;
         if (i_valid) begin
            env      <= env_nxt;
            x_p0     <= i_data;
            mag_p0   <= mag_in;
            thr_p0   <= i_threshold;
            ratio_p0 <= i_ratio_shift;
            byp_p0   <= i_bypass;
         end
         // Stage 2: gain reduction and output register.
         o_valid <= vld_p0;
         if (vld_p0) begin
            o_data   <= out_p0;
            o_env    <= env;
            o_active <= (over_p0 != '0);
         end
      end
   end

endmodule

// File: tb/tb_dyn_compressor.sv
module tb_dyn_compressor;

   localparam int W    = 8;
   localparam int AS   = 2;
   localparam int RS   = 4;
   localparam int MAXM = (1 << (W-1)) - 1;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_valid;
   logic signed [W-1:0] i_data;
   logic        [W-2:0] i_threshold;
   logic        [2:0]   i_ratio_shift;
   logic                i_bypass;
   logic                o_valid;
   logic signed [W-1:0] o_data;
   logic        [W-2:0] o_env;
   logic                o_active;

   dyn_compressor #(.W(W), .ATTACK_SHIFT(AS), .RELEASE_SHIFT(RS)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_threshold  (i_threshold),
      .i_ratio_shift(i_ratio_shift),
      .i_bypass     (i_bypass),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_env        (o_env),
      .o_active     (o_active)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int due;
      int data;
      int act;
      int env;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   m_env  = 0;
   int   n_chk  = 0;
   int   n_err  = 0;

   always @(posedge i_clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: envelope follower and gain computer on plain integers.
   task automatic model_push(input int x, input int t, input int r, input int b);
      int   mag, over, red, omag;
      exp_t e;
      if (x < 0) mag = (x == -(1 << (W-1))) ? MAXM : -x;
      else       mag = x;
      if (mag > m_env)      m_env = m_env + ((mag - m_env) >> AS);
      else if (mag < m_env) m_env = m_env - ((m_env - mag) >> RS);
      over = (m_env > t) ? m_env - t : 0;
      red  = over - (over >> r);
      omag = (mag > red) ? mag - red : 0;
      e.due  = cyc + 2;
      e.data = b ? x : ((x < 0) ? -omag : omag);
      e.act  = (over != 0) ? 1 : 0;
      e.env  = m_env;
      q.push_back(e);
   endtask

   task automatic drive(input bit v, input int x, input int t, input int r, input bit b);
      @(posedge i_clk);
      #1;
      i_valid       = v;
      i_data        = x[W-1:0];
      i_threshold   = t[W-2:0];
      i_ratio_shift = r[2:0];
      i_bypass      = b;
      if (v) model_push(x, t, r, int'(b));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      i_valid = 1'b0;
      q.delete();
      m_env = 0;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      chk("rst_valid",  o_valid,  0);
      chk("rst_data",   o_data,   0);
      chk("rst_env",    o_env,    0);
      chk("rst_active", o_active, 0);
   endtask

   // Scoreboard: an output is required exactly on the cycle its sample fell due.
   always @(negedge i_clk) begin
      exp_t e;
      bit   due_now;
      due_now = (q.size() > 0) && (q[0].due == cyc);
      chk("o_valid", o_valid, due_now ? 1 : 0);
      if (due_now) begin
         e = q.pop_front();
         chk("o_data",   o_data,   e.data);
         chk("o_active", o_active, e.act);
         chk("o_env",    o_env,    e.env);
      end
   end

   initial begin
      i_reset       = 1'b1;
      i_valid       = 1'b0;
      i_data        = '0;
      i_threshold   = '0;
      i_ratio_shift = '0;
      i_bypass      = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      chk("init_valid", o_valid, 0);
      chk("init_env",   o_env,   0);

      // Below threshold: envelope climbs toward 50, no reduction.
      for (int i = 0; i < 20; i++) drive(1'b1, 50, 64, 1, 1'b0);
      idle(3);

      // Attack step from a cleared envelope: env 30, 52, 69.
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 120, 64, 1, 1'b0);
      idle(3);

      // Most negative input with heavy compression: magnitude saturates to 127.
      for (int i = 0; i < 10; i++) drive(1'b1, 127, 0, 7, 1'b0);
      for (int i = 0; i < 3; i++)  drive(1'b1, -128, 0, 7, 1'b0);
      idle(3);

      // Release with i_valid gaps, envelope holds through the gaps.
      for (int i = 0; i < 30; i++) drive(1'b1, 100, 127, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 0, 127, 0, 1'b0);
         idle(i % 3);
      end
      idle(3);

      // Bypass with gaps: exact pass-through, envelope still tracking.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, -100, 10, 3, 1'b1);
         if (i % 2 == 1) idle(1);
      end
      idle(3);

      // Threshold at full scale never compresses; R=0 never reduces.
      for (int i = 0; i < 10; i++)
         drive(1'b1, $signed(8'($urandom)), 127, 4, 1'b0);
      for (int i = 0; i < 10; i++)
         drive(1'b1, $signed(8'($urandom)), 0, 0, 1'b0);
      idle(3);

      // Mid-stream reset: one sample in stage 1, another on the input.
      drive(1'b1, 90, 20, 2, 1'b0);
      @(posedge i_clk);
      #1;
      i_valid = 1'b1;
      i_data  = 8'sd77;
      i_reset = 1'b1;
      q.delete();
      m_env = 0;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_valid = 1'b0;
      chk("mid_rst_valid",  o_valid,  0);
      chk("mid_rst_data",   o_data,   0);
      chk("mid_rst_env",    o_env,    0);
      chk("mid_rst_active", o_active, 0);
      idle(2);
      drive(1'b1, 40, 64, 1, 1'b0);
      idle(3);

      // Random stream with per-sample threshold, ratio and bypass changes.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(3, 0) != 0),
               $signed(8'($urandom)),
               ($urandom_range(7, 0) == 0) ? 127 : int'($urandom_range(100, 0)),
               int'($urandom_range(7, 0)),
               ($urandom_range(7, 0) == 0));
      end
      drive(1'b0, 0, 0, 0, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge i_clk);
      #1;
      chk("drain_left", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
